// File: rtl/dt_estimator_mc.sv
// Multi-channel dT estimator: one EMA of successive temperature differences per
// channel, sharing a single arithmetic datapath. Samples are tagged with a channel
// index. Results leave through a registered valid/ready output stage.
module dt_estimator_mc #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned TW     = 8,
    parameter int unsigned FRAC   = 7,
    parameter int unsigned WARMUP = 2,
    localparam int unsigned CHW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CHW-1:0]  in_ch,
    input  logic [TW-1:0]   in_T,
    input  logic [7:0]      alpha,
    input  logic [3:0]      k_dt,
    input  logic [TW-2:0]   d_max,
    input  logic [N_CH-1:0] init_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CHW-1:0]  out_ch,
    output logic [TW-1:0]   out_dT,
    output logic            out_sat,
    output logic            out_warm
);

    localparam int unsigned DW = TW + 1;         // raw difference width
    localparam int unsigned EW = TW + FRAC + 1;  // EMA state width
    localparam int unsigned SW = EW + 10;        // weighted-sum width
    localparam int unsigned LW = SW - 8;         // width after the /256

    // Per-channel state
    logic [TW-1:0]        t_prev_q [N_CH];
    logic [TW-1:0]        t_prev_d [N_CH];
    logic signed [EW-1:0] ema_q    [N_CH];
    logic signed [EW-1:0] ema_d    [N_CH];
    logic [3:0]           cnt_q    [N_CH];
    logic [3:0]           cnt_d    [N_CH];
    logic [N_CH-1:0]      primed_q, primed_d;

    // Output register stage
    logic           out_valid_q, out_valid_d;
    logic [CHW-1:0] out_ch_q, out_ch_d;
    logic [TW-1:0]  out_dt_q, out_dt_d;
    logic           out_sat_q, out_sat_d;
    logic           out_warm_q, out_warm_d;

    logic accept, ch_ok;

    // Selected channel state
    logic [TW-1:0]        sel_t;
    logic signed [EW-1:0] sel_ema;
    logic [3:0]           sel_cnt;
    logic                 sel_primed, sel_init, live_primed;

    // Datapath
    logic [3:0]           kk;
    logic signed [DW-1:0] delta;
    logic signed [EW-1:0] d_sh;
    logic signed [SW-1:0] ema_x, d_x, a_new, a_old, sum;
    logic signed [LW-1:0] e, lim, ec, rnd;
    logic                 sat;
    logic [TW-1:0]        dt_val;
    logic [3:0]           cnt_inc;
    logic                 warm;
    logic                 unused_bits;

    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign ch_ok    = 32'(in_ch) < N_CH;

    // Read the state of the addressed channel; a coincident init makes it look fresh
    always_comb begin
        sel_t      = '0;
        sel_ema    = '0;
        sel_cnt    = '0;
        sel_primed = 1'b0;
        sel_init   = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (32'(in_ch) == i) begin
                sel_t      = t_prev_q[i];
                sel_ema    = ema_q[i];
                sel_cnt    = cnt_q[i];
                sel_primed = primed_q[i];
                sel_init   = init_ch[i];
            end
        end
        live_primed = sel_primed && !sel_init;
    end

    // Shared EMA datapath: scale, weight, floor-divide, clamp, truncate toward zero
    always_comb begin
        kk    = (32'(k_dt) > FRAC) ? 4'(FRAC) : k_dt;
        delta = $signed({in_T[TW-1], in_T}) - $signed({sel_t[TW-1], sel_t});
        d_sh  = $signed({delta, {FRAC{1'b0}}}) >>> kk;
        ema_x = {{(SW-EW){sel_ema[EW-1]}}, sel_ema};
        d_x   = {{(SW-EW){d_sh[EW-1]}}, d_sh};
        a_new = {{(SW-8){1'b0}}, alpha};
        a_old = {{(SW-9){1'b0}}, (9'd256 - {1'b0, alpha})};
        sum   = ema_x * a_old + d_x * a_new;
        // Dropping the low byte of a two's-complement value is a floor divide by 256
        e     = sum[SW-1:8];
        lim   = {{(LW-(TW-1)-FRAC){1'b0}}, d_max, {FRAC{1'b0}}};
        ec    = e;
        sat   = 1'b0;
        if (e > lim) begin
            ec  = lim;
            sat = 1'b1;
        end else if (e < -lim) begin
            ec  = -lim;
            sat = 1'b1;
        end
        // Bias negatives so the floor shift truncates toward zero
        rnd     = ec[LW-1] ? (ec + {{(LW-FRAC){1'b0}}, {FRAC{1'b1}}}) : ec;
        dt_val  = rnd[FRAC+TW-1:FRAC];
        cnt_inc = (32'(sel_cnt) >= WARMUP) ? 4'(WARMUP) : (sel_cnt + 4'd1);
        warm    = 32'(cnt_inc) >= WARMUP;
    end

    assign unused_bits = ^{sum[7:0], rnd[LW-1:FRAC+TW], rnd[FRAC-1:0], ec[LW-1:EW]};

    // Per-channel state update: init clears first, then an accepted sample writes
    always_comb begin
        t_prev_d = t_prev_q;
        ema_d    = ema_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (init_ch[i]) begin
                t_prev_d[i] = '0;
                ema_d[i]    = '0;
                cnt_d[i]    = '0;
                primed_d[i] = 1'b0;
            end
            if (accept && ch_ok && (32'(in_ch) == i)) begin
                t_prev_d[i] = in_T;
                primed_d[i] = 1'b1;
                if (live_primed) begin
                    ema_d[i] = ec[EW-1:0];
                    cnt_d[i] = cnt_inc;
                end
            end
        end
    end

    // Output stage: load on accept, drop valid once consumed, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_ch_d    = out_ch_q;
        out_dt_d    = out_dt_q;
        out_sat_d   = out_sat_q;
        out_warm_d  = out_warm_q;
        if (accept && ch_ok) begin
            out_valid_d = 1'b1;
            out_ch_d    = in_ch;
            out_dt_d    = live_primed ? dt_val : '0;
            out_sat_d   = live_primed && sat;
            out_warm_d  = live_primed && warm;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                t_prev_q[i] <= '0;
                ema_q[i]    <= '0;
                cnt_q[i]    <= '0;
            end
            primed_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_dt_q    <= '0;
            out_sat_q   <= 1'b0;
            out_warm_q  <= 1'b0;
        end else begin
            t_prev_q    <= t_prev_d;
            ema_q       <= ema_d;
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_dt_q    <= out_dt_d;
            out_sat_q   <= out_sat_d;
            out_warm_q  <= out_warm_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_dT    = out_dt_q;
    assign out_sat   = out_sat_q;
    assign out_warm  = out_warm_q;

endmodule

// File: tb/tb_dt_estimator_mc.sv
// Bench for dt_estimator_mc: directed vector table, hand-written backpressure and
// reset sequences, then random traffic against an arithmetic reference model.
module tb_dt_estimator_mc;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_ch;
    logic [7:0] in_T;
    logic [7:0] alpha;
    logic [3:0] k_dt;
    logic [6:0] d_max;
    logic [3:0] init_ch;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_ch;
    logic [7:0] out_dT;
    logic       out_sat;
    logic       out_warm;

    dt_estimator_mc #(.N_CH(4), .TW(8), .FRAC(7), .WARMUP(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ch    (in_ch),
        .in_T     (in_T),
        .alpha    (alpha),
        .k_dt     (k_dt),
        .d_max    (d_max),
        .init_ch  (init_ch),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .out_dT   (out_dT),
        .out_sat  (out_sat),
        .out_warm (out_warm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int dt;
        int sat;
        int warm;
    } exp_t;

    typedef struct {
        int ch;
        int t;
        int a;
        int k;
        int dm;
        int init;
        int dt;
        int sat;
        int warm;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sbq[$];
    vec_t vt[16];
    vec_t cur_vec;
    bit   chk_vec  = 0;
    bit   chk_zero = 0;

    // Reference state per channel
    int m_tp[4];
    int m_ema[4];
    int m_cnt[4];
    bit m_pr[4];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tp[i]  = 0;
            m_ema[i] = 0;
            m_cnt[i] = 0;
            m_pr[i]  = 0;
        end
        sbq.delete();
    endtask

    task automatic model_accept(input int c, input int tv, input int a, input int k,
                                input int dm);
        exp_t x;
        int   d, s, e, lim;
        x.ch = c;
        if (!m_pr[c]) begin
            m_tp[c] = tv;
            m_pr[c] = 1;
            x.dt = 0; x.sat = 0; x.warm = 0;
        end else begin
            if (k > 7) k = 7;
            d   = fdiv((tv - m_tp[c]) * 128, 1 << k);
            s   = m_ema[c] * (256 - a) + d * a;
            e   = fdiv(s, 256);
            lim = dm * 128;
            x.sat = 0;
            if (e > lim) begin
                e = lim; x.sat = 1;
            end else if (e < -lim) begin
                e = -lim; x.sat = 1;
            end
            m_ema[c] = e;
            m_tp[c]  = tv;
            m_cnt[c] = (m_cnt[c] + 1 > 2) ? 2 : m_cnt[c] + 1;
            x.dt   = e / 128;
            x.warm = (m_cnt[c] >= 2) ? 1 : 0;
        end
        sbq.push_back(x);
    endtask

    // One clock: check outputs at the falling edge, update the model, advance past posedge
    task automatic tick();
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = !rst && (sbq.size() == 0 || out_ready);
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        chk("out_valid", int'(out_valid), int'(sbq.size() != 0));
        if (sbq.size() != 0) begin
            if (out_valid) begin
                chk("sb_ch", int'(out_ch), sbq[0].ch);
                chk("sb_dT", int'($signed(out_dT)), sbq[0].dt);
                chk("sb_sat", int'(out_sat), sbq[0].sat);
                chk("sb_warm", int'(out_warm), sbq[0].warm);
            end
            if (out_ready) void'(sbq.pop_front());
        end
        if (chk_vec) begin
            chk_vec = 0;
            chk("vec_valid", int'(out_valid), 1);
            chk("vec_ch", int'(out_ch), cur_vec.ch);
            chk("vec_dT", int'($signed(out_dT)), cur_vec.dt);
            chk("vec_sat", int'(out_sat), cur_vec.sat);
            chk("vec_warm", int'(out_warm), cur_vec.warm);
        end
        if (chk_zero) begin
            chk_zero = 0;
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_ch", int'(out_ch), 0);
            chk("rst_dT", int'(out_dT), 0);
            chk("rst_sat", int'(out_sat), 0);
            chk("rst_warm", int'(out_warm), 0);
        end
        if (rst) begin
            model_reset();
            chk_zero = 1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (init_ch[i]) begin
                    m_tp[i] = 0; m_ema[i] = 0; m_cnt[i] = 0; m_pr[i] = 0;
                end
            end
            if (in_valid && exp_rdy)
                model_accept(int'(in_ch), int'($signed(in_T)), int'(alpha), int'(k_dt),
                             int'(d_max));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dir(input vec_t v);
        in_valid  = 1'b1;
        in_ch     = 2'(v.ch);
        in_T      = 8'(v.t);
        alpha     = 8'(v.a);
        k_dt      = 4'(v.k);
        d_max     = 7'(v.dm);
        init_ch   = 4'(v.init);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        init_ch  = '0;
        cur_vec  = v;
        chk_vec  = 1;
        tick();
    endtask

    initial begin
        //        ch    T    a  k   dm init  dT sat warm
        vt[0]  = '{0,   10, 128, 0, 127, 0,   0, 0, 0};
        vt[1]  = '{0,   20, 128, 0, 127, 0,   5, 0, 0};
        vt[2]  = '{0,   30, 128, 0, 127, 0,   7, 0, 1};
        vt[3]  = '{1,   20, 128, 0, 127, 0,   0, 0, 0};
        vt[4]  = '{1,   10, 128, 0, 127, 0,  -5, 0, 0};
        vt[5]  = '{1,   10, 128, 0, 127, 0,  -2, 0, 1};
        vt[6]  = '{2,    0, 255, 0,   3, 0,   0, 0, 0};
        vt[7]  = '{2,  100, 255, 0,   3, 0,   3, 1, 0};
        vt[8]  = '{2, -100, 255, 0,   3, 0,  -3, 1, 1};
        vt[9]  = '{0,   50, 128, 0, 127, 1,   0, 0, 0};
        vt[10] = '{0,   60, 128, 0, 127, 0,   5, 0, 0};
        vt[11] = '{3,    0, 128, 0, 127, 0,   0, 0, 0};
        vt[12] = '{3,   40, 255, 3, 127, 0,   4, 0, 0};
        vt[13] = '{3,   40,   0, 15, 127, 0,  4, 0, 1};
        vt[14] = '{3,  -20, 128, 0, 127, 1, -27, 0, 1};
        vt[15] = '{0,    5, 128, 0, 127, 0,   0, 0, 0};

        rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_T = '0; alpha = 8'd128;
        k_dt = '0; d_max = 7'd127; init_ch = '0; out_ready = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) dir(vt[i]);

        // Backpressure: one result waiting, input offered while the sink stalls
        in_valid = 1'b1; in_ch = 2'd0; in_T = 8'd70; alpha = 8'd128; k_dt = '0;
        d_max = 7'd127; out_ready = 1'b1;
        tick();
        in_T = 8'd80; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b1;
        tick();
        in_T = 8'd95;
        tick();
        in_ch = 2'd3; in_T = 8'd90;
        tick();
        in_valid = 1'b0;
        tick();
        tick();

        // Reset mid-stream with an output pending and a sample offered
        in_valid = 1'b1; in_ch = 2'd1; in_T = 8'd33; out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; in_T = 8'd40; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        dir('{1, 50, 128, 0, 127, 0, 5, 0, 0});

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_ch     = 2'($urandom_range(0, 3));
            in_T      = 8'($urandom);
            alpha     = 8'($urandom);
            k_dt      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 2));
            d_max     = ($urandom_range(0, 1) == 0) ? 7'd127 : 7'($urandom);
            init_ch   = ($urandom_range(0, 31) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end

        rst = 1'b0; in_valid = 1'b0; init_ch = '0; out_ready = 1'b1;
        tick();
        tick();
        chk("drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dt_estimator_mc.md
# dt_estimator_mc

Multi-channel, parametrised successor of the single-channel dT estimator. It keeps one exponential moving average (EMA) of T[n]−T[n−1] per channel, time-multiplexed over one shared arithmetic datapath. Samples enter through a valid/ready handshake tagged with a channel index, and results leave through a registered valid/ready output. Added over the single-channel block: per-channel priming and warm-up qualification, a saturation flag, and output backpressure. It sits between the multi-sensor temperature front end and the fuzzy-controller input stage.

## Interface
- N_CH, 4: number of channels, ≥1; CHW = max(1, $clog2(N_CH))
- TW, 8: temperature and dT width, signed Q(TW−1).0
- FRAC, 7: internal fractional bits (state is Q.FRAC)
- WARMUP, 2: accepted post-priming samples before out_warm asserts, 1..15
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_ch  in  CHW  channel index; indices ≥ N_CH are accepted and dropped (no state change, no output)
- in_T  in  TW  signed sample
- alpha  in  8  EMA weight, alpha/256
- k_dt  in  4  scale shift 2^k, clamped to FRAC
- d_max  in  TW−1  unsigned magnitude clamp, Q.0
- init_ch  in  N_CH  per-channel init, one-cycle pulse per bit
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_ch  out  CHW  channel of result
- out_dT  out  TW  signed dT, Q.0, truncated toward zero
- out_sat  out  1  clamp was active for this result
- out_warm  out  1  channel has ≥WARMUP post-priming samples

## Operation
- Per-channel state: T_prev[TW], ema[TW+FRAC+1] signed, primed flag, cnt[4] (saturates at WARMUP).
- in_ready = !rst && (!out_valid || out_ready).
- Accepted sample on channel c, unprimed (after reset or init):
  - T_prev ← in_T, primed ← 1, ema and cnt unchanged (0).
  - Emits out_dT=0, out_sat=0, out_warm=0.
- Accepted sample on channel c, primed:
  - delta = in_T − T_prev (TW+1 bits), then d = (delta <<< FRAC) >>> min(k_dt, FRAC).
  - sum = ema·(256−alpha) + d·alpha at full precision; e = sum >>> 8 (arithmetic, floor).
  - Clamp e to ±(d_max <<< FRAC); out_sat = clamp active.
  - ema ← clamped e; T_prev ← in_T; cnt ← min(cnt+1, WARMUP).
  - out_dT = (clamped e < 0 ? e + (2^FRAC−1) : e) >>> FRAC.
  - out_warm = (new cnt ≥ WARMUP).
- init_ch[c] clears channel c: primed=0, ema=0, cnt=0, T_prev=0.
  - If a sample on c is accepted in the same cycle, that sample acts as the priming sample: T_prev ← in_T, primed=1, output dT=0, warm=0.
  - init on other channels does not disturb the sample in flight.
- Channels are fully independent; interleaving order does not affect any channel's results.
- alpha, k_dt and d_max are sampled at acceptance.

## Timing
- Latency: accept at edge n gives out_valid from edge n+1. One sample per cycle sustained when out_ready=1.
- Output registers hold stable while out_valid && !out_ready. New accepts are blocked in that state.
- Same channel back-to-back: the second sample must use the state written by the first. This requires a write-through state array and no stall.
- Reset (any cycle, including mid-stream):
  - out_valid=0, out_ch=0, out_dT=0, out_sat=0, out_warm=0.
  - All channels unprimed with ema=0, cnt=0, T_prev=0.
  - in_ready=0 while rst=1. An output pending at reset is discarded.
- cnt saturates at WARMUP and does not wrap.

## Test plan
- Defaults (alpha=128, k=0, d_max=127): ch0 samples 10, 20, 30 → outputs dT=0/warm=0, then dT=5/warm=0 (ema 640), then dT=7/warm=1 (ema 960).
- Negative: ch1 primed at 20, then 10 with alpha=128 → ema=−640, out_dT=−5. Then 10 again → ema=−320, out_dT=−2 (truncation toward zero).
- Clamp: alpha=255, d_max=3, ch2 samples 0 then 100 → e=12750 clamped to 384, out_dT=3, out_sat=1.
- Interleave: ch0/ch3 alternating back-to-back, plus consecutive same-channel samples → per-channel results match the isolated-channel golden model.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, output held stable, no sample lost. Release → one result per cycle.
- Init and reset:
  - init_ch[0] coincident with a ch0 sample of 50 → dT=0, warm=0; the next sample of 60 → dT=5.
  - Assert rst mid-stream → all outputs 0; the first sample after release primes.
